mc_main_fsm: RTL

Multicycle main controller for the RISC-V core: a Moore state machine that sequences each instruction over 3–5 cycles and drives the shared-ALU datapath strobes and mux selects. It replaces the single-cycle opcode decoder and adds jalr, lui and auipc support, a memory-ready handshake, illegal-opcode trapping and a retired-instruction counter. It sits between the instruction register (`op` field) and the multicycle datapath; ALU function decode stays external and is driven by `ALUOp`.

---
 rtl/riscv_ctrl_pkg.sv | 97 +++++++++
 rtl/imm_src_dec.sv | 29 ++
 rtl/mc_main_fsm.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V main controller: the FSM
// state enum, opcode constants, datapath mux-select encodings, the
// packed control word driven by the output decoder, and the opcode
// dispatch used in DECODE.
package riscv_ctrl_pkg;

    // 4-bit state encoding; the value is also exported on state_dbg.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    // Major opcodes recognised by the controller.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Immediate formats.
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // ALU operand A select.
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU operand B select.
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ALU operation class handed to the external ALU decoder.
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    // Result bus select.
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Complete control word produced by the output decoder each cycle.
    typedef struct packed {
        logic       pc_update;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       adr_src;
        logic       mem_req;
        logic       instr_done;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
    } ctrl_t;

    // Opcode dispatch out of DECODE; anything unrecognised traps.
    function automatic state_t decode_next(input logic [6:0] op);
        case (op)
            OP_LOAD,
            OP_STORE:  decode_next = S_MEMADR;
            OP_RTYPE:  decode_next = S_EXECR;
            OP_ITYPE:  decode_next = S_EXECI;
            OP_BRANCH: decode_next = S_BEQ;
            OP_JAL:    decode_next = S_JAL;
            OP_JALR:   decode_next = S_JALR;
            OP_LUI:    decode_next = S_LUI;
            OP_AUIPC:  decode_next = S_AUIPC;
            default:   decode_next = S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/imm_src_dec.sv
// Immediate-format decoder: a purely combinational map from the opcode
// to ImmSrc. Opcodes without an immediate (and unknown opcodes) give the
// I format encoding, 000.
module imm_src_dec
    import riscv_ctrl_pkg::*;
#(
    parameter int IMM_W = 3
) (
    input  logic [6:0]       op,
    output logic [IMM_W-1:0] imm_src
);

    // Select the immediate layout for the current opcode.
    always_comb begin
        imm_src = IMM_W'(IMM_I);
        case (op)
            OP_LOAD,
            OP_ITYPE,
            OP_JALR:   imm_src = IMM_W'(IMM_I);
            OP_STORE:  imm_src = IMM_W'(IMM_S);
            OP_BRANCH: imm_src = IMM_W'(IMM_B);
            OP_JAL:    imm_src = IMM_W'(IMM_J);
            OP_LUI,
            OP_AUIPC:  imm_src = IMM_W'(IMM_U);
            default:   imm_src = IMM_W'(IMM_I);
        endcase
    end

endmodule

// File: rtl/mc_main_fsm.sv
// Multicycle main controller. A Moore FSM sequences each instruction over
// 3-5 cycles and drives the shared-ALU datapath strobes and mux selects,
// traps illegal opcodes and counts retired instructions.
//
// Build option: define MC_MAIN_FSM_MEM_WAIT_EN to make FETCH, MEMREAD and
// MEMWRITE wait for mem_ready; without it mem_ready is ignored and every
// memory state lasts one cycle.
//
// Memory handshake: mem_req acts as "valid" and mem_ready as "ready"; an
// access completes on a rising edge where both are high. With waiting
// enabled, mem_req, AdrSrc and MemWrite stay stable while mem_ready is low,
// and the IR/PC strobes of FETCH fire only in the completing cycle.
module mc_main_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int IMM_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       op,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCUpdate,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             Branch,
    output logic             AdrSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ResultSrc,
    output logic [IMM_W-1:0] ImmSrc,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_dbg
);

    state_t     state;
    state_t     state_next;
    ctrl_t      ctrl;
    logic       run;
    logic       mem_wait;
    logic [CNT_W-1:0] count_q;

`ifdef MC_MAIN_FSM_MEM_WAIT_EN
    // A memory state is held while the memory has not completed.
    assign mem_wait = ~mem_ready;
`else
    // Memory always completes in one cycle; mem_ready is not observed.
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_wait = 1'b0;
`endif

    // Run flag: low through reset and the first cycle after release, so
    // the controller idles one cycle in FETCH before issuing anything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; op is only consulted in DECODE and MEMADR.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    state_next = (run && !mem_wait) ? S_DECODE : S_FETCH;
            S_DECODE:   state_next = decode_next(op);
            S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = mem_wait ? S_MEMREAD : S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = mem_wait ? S_MEMWRITE : S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_JALR:     state_next = S_JAL;
            S_LUI:      state_next = S_ALUWB;
            S_AUIPC:    state_next = S_ALUWB;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    // Output decode: per-state control word, strobes gated by the run flag.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.ir_write   = ~mem_wait;
                ctrl.pc_update  = ~mem_wait;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                // Precompute OldPC + imm as the branch/jal target.
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = ~mem_wait;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BEQ: begin
                // PC loads the DECODE-computed target only if Zero is set.
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_BRANCH;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JAL: begin
                // PC <= ALUOut (target) while the ALU forms OldPC + 4.
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
            S_JALR: begin
                // Overwrite ALUOut with rs1 + imm so JAL jumps there.
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_LUI: begin
                ctrl.alu_src_a = SRCA_ZERO;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_AUIPC: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_TRAP: begin
                ctrl = '0;
            end
            default: begin
                ctrl = '0;
            end
        endcase
        if (!run) begin
            ctrl.pc_update  = 1'b0;
            ctrl.ir_write   = 1'b0;
            ctrl.reg_write  = 1'b0;
            ctrl.mem_write  = 1'b0;
            ctrl.branch     = 1'b0;
            ctrl.mem_req    = 1'b0;
            ctrl.instr_done = 1'b0;
        end
    end

    // Retired-instruction counter; wraps modulo 2^CNT_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (ctrl.instr_done) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    imm_src_dec #(
        .IMM_W (IMM_W)
    ) u_imm_src_dec (
        .op      (op),
        .imm_src (ImmSrc)
    );

    assign PCUpdate    = ctrl.pc_update;
    assign IRWrite     = ctrl.ir_write;
    assign RegWrite    = ctrl.reg_write;
    assign MemWrite    = ctrl.mem_write;
    assign Branch      = ctrl.branch;
    assign AdrSrc      = ctrl.adr_src;
    assign mem_req     = ctrl.mem_req;
    assign instr_done  = ctrl.instr_done;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign ResultSrc   = ctrl.result_src;
    // TRAP is absorbing until reset, so this flag is sticky.
    assign illegal_op  = (state == S_TRAP);
    assign instr_count = count_q;
    assign state_dbg   = state;

endmodule
